// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed TX path.
package usb_pkg;

    typedef enum logic [1:0] {
        LM_OFF  = 2'd0,
        LM_DATA = 2'd1,
        LM_SE0  = 2'd2,
        LM_J    = 2'd3
    } line_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4,
        ST_GAP     = 3'd5
    } tx_seq_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         EOP_SE0_BITS = 2;
    localparam int         EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and emits a registered one-clock tick on the last count.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_next;
    logic         tick_r;

    // Next divider value: clear wins, otherwise wrap at LAST while enabled.
    always_comb begin
        cnt_next = cnt_r;
        if (clear) begin
            cnt_next = {W{1'b0}};
        end else if (enable) begin
            if (cnt_r == LAST) begin
                cnt_next = {W{1'b0}};
            end else begin
                cnt_next = cnt_r + W'(1);
            end
        end else begin
            cnt_next = cnt_r;
        end
    end

    // Divider and tick registers; tick mirrors cnt_r == LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next;
            tick_r <= (cnt_next == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB full-speed TX controller: line ownership, bit timing, SYNC/data byte handshake,
// stuff-bit stalls, EOP (SE0 SE0 J) and inter-packet gap.
module usb_tx_sequencer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       rx_active,
    input  logic       stuff_stall,
    output logic [7:0] piso_data,
    output logic       piso_load,
    output logic       bit_tick,
    output logic [1:0] line_mode,
    output logic       tx_1_rx_0
);

    localparam int             EW       = $clog2(GAP_BITS + 3);
    localparam logic [EW-1:0]  SE0_LAST = EW'(EOP_SE0_BITS - 1);
    localparam logic [EW-1:0]  J_LAST   = EW'(EOP_J_BITS - 1);
    localparam logic [EW-1:0]  GAP_LAST = EW'(GAP_BITS - 1);

    tx_seq_state_t state_r,     state_next;
    line_mode_t    mode_r,      mode_next;
    logic [2:0]    bit_cnt_r,   bit_cnt_next;
    logic [EW-1:0] eop_cnt_r,   eop_cnt_next;
    logic          end_pend_r,  end_pend_next;
    logic          sync_load_r, sync_load_next;
    logic          drive_r,     drive_next;
    logic          tick_s;
    logic          timer_clear_s;
    logic          in_byte_s;
    logic          boundary_s;

    // The bit period restarts on leaving IDLE; later loads always land on a wrap.
    assign timer_clear_s = (state_r == ST_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (RST),
        .clear  (timer_clear_s),
        .enable (!timer_clear_s),
        .tick   (tick_s)
    );

    // Byte-boundary handshake and PISO load decode.
    always_comb begin
        in_byte_s  = (state_r == ST_SYNC) || (state_r == ST_DATA);
        boundary_s = in_byte_s && tick_s && !stuff_stall && !end_pend_r && (bit_cnt_r == 3'd7);
        tx_ready   = boundary_s && tx_valid;
        piso_load  = sync_load_r || tx_ready;
        if (sync_load_r) begin
            piso_data = SYNC_BYTE;
        end else if (tx_ready) begin
            piso_data = tx_data;
        end else begin
            piso_data = 8'h00;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_next     = state_r;
        mode_next      = mode_r;
        bit_cnt_next   = bit_cnt_r;
        eop_cnt_next   = eop_cnt_r;
        end_pend_next  = end_pend_r;
        sync_load_next = 1'b0;
        drive_next     = drive_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_valid && !rx_active) begin
                    state_next     = ST_SYNC;
                    mode_next      = LM_DATA;
                    drive_next     = 1'b1;
                    sync_load_next = 1'b1;
                    bit_cnt_next   = 3'd0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (tick_s && !stuff_stall) begin
                    if (end_pend_r) begin
                        state_next    = ST_EOP_SE0;
                        mode_next     = LM_SE0;
                        end_pend_next = 1'b0;
                        eop_cnt_next  = {EW{1'b0}};
                    end else if (bit_cnt_r == 3'd7) begin
                        state_next    = ST_DATA;
                        bit_cnt_next  = 3'd0;
                        end_pend_next = !tx_valid;
                    end else begin
                        bit_cnt_next = bit_cnt_r + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_r;
                end
            end
            ST_EOP_SE0: begin
                if (tick_s) begin
                    if (eop_cnt_r == SE0_LAST) begin
                        state_next   = ST_EOP_J;
                        mode_next    = LM_J;
                        eop_cnt_next = {EW{1'b0}};
                    end else begin
                        eop_cnt_next = eop_cnt_r + EW'(1);
                    end
                end else begin
                    eop_cnt_next = eop_cnt_r;
                end
            end
            ST_EOP_J: begin
                if (tick_s) begin
                    if (eop_cnt_r == J_LAST) begin
                        state_next   = ST_GAP;
                        mode_next    = LM_OFF;
                        drive_next   = 1'b0;
                        eop_cnt_next = {EW{1'b0}};
                    end else begin
                        eop_cnt_next = eop_cnt_r + EW'(1);
                    end
                end else begin
                    eop_cnt_next = eop_cnt_r;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    if (eop_cnt_r == GAP_LAST) begin
                        state_next   = ST_IDLE;
                        eop_cnt_next = {EW{1'b0}};
                        bit_cnt_next = 3'd0;
                    end else begin
                        eop_cnt_next = eop_cnt_r + EW'(1);
                    end
                end else begin
                    eop_cnt_next = eop_cnt_r;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                mode_next     = LM_OFF;
                drive_next    = 1'b0;
                bit_cnt_next  = 3'd0;
                eop_cnt_next  = {EW{1'b0}};
                end_pend_next = 1'b0;
            end
        endcase
    end

    // State and counter registers; RST aborts any packet without an EOP.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            mode_r      <= LM_OFF;
            bit_cnt_r   <= 3'd0;
            eop_cnt_r   <= {EW{1'b0}};
            end_pend_r  <= 1'b0;
            sync_load_r <= 1'b0;
            drive_r     <= 1'b0;
        end else begin
            state_r     <= state_next;
            mode_r      <= mode_next;
            bit_cnt_r   <= bit_cnt_next;
            eop_cnt_r   <= eop_cnt_next;
            end_pend_r  <= end_pend_next;
            sync_load_r <= sync_load_next;
            drive_r     <= drive_next;
        end
    end

    assign bit_tick  = tick_s;
    assign line_mode = mode_r;
    assign tx_1_rx_0 = drive_r;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: directed packets push expected load/line events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_usb_tx_sequencer;
    import usb_pkg::*;

    logic       clk;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_active;
    logic       stuff_stall;
    logic [7:0] piso_data;
    logic       piso_load;
    logic       bit_tick;
    logic [1:0] line_mode;
    logic       tx_1_rx_0;

    usb_tx_sequencer #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut (
        .clk         (clk),
        .RST         (RST),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_active   (rx_active),
        .stuff_stall (stuff_stall),
        .piso_data   (piso_data),
        .piso_load   (piso_load),
        .bit_tick    (bit_tick),
        .line_mode   (line_mode),
        .tx_1_rx_0   (tx_1_rx_0)
    );

    typedef struct {
        bit         is_line;
        logic [7:0] data;
        logic       ready;
        logic [1:0] lm;
        logic       tx;
        int         stamp;
    } ev_t;

    ev_t        sb[$];
    int         stall_q[$];
    logic [7:0] pkt [0:7];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input bit is_line, input logic [7:0] d, input logic r,
                           input logic [1:0] lm, input logic tx, input int stamp);
        ev_t e;
        e.is_line = is_line; e.data = d; e.ready = r; e.lm = lm; e.tx = tx; e.stamp = stamp;
        sb.push_back(e);
    endtask

    // Expected events of a packet whose start is seen at stamp k; byte d stretched by one
    // stuff tick, se adds a trailing stuff tick before EOP, trunc drops the EOP events.
    task automatic exp_pkt(input int k, input int n, input int d, input int se, input bit trunc);
        int t;
        int extra;
        extra = 0;
        push_ev(1'b1, 8'h00, 1'b0, LM_DATA, 1'b1, k + 1);
        push_ev(1'b0, 8'h80, 1'b0, 2'd0, 1'b0, k + 1);
        for (int i = 0; i < n; i++) begin
            t = k + 32 * (i + 1) + extra;
            push_ev(1'b0, pkt[i], 1'b1, 2'd0, 1'b0, t);
            if (i == d) extra += 4;
        end
        if (!trunc) begin
            t = k + 32 * n + 37 + extra + 4 * se;
            push_ev(1'b1, 8'h00, 1'b0, LM_SE0, 1'b1, t);
            push_ev(1'b1, 8'h00, 1'b0, LM_J,   1'b1, t + 8);
            push_ev(1'b1, 8'h00, 1'b0, LM_OFF, 1'b0, t + 12);
        end
    endtask

    task automatic mon_check(input bit is_line);
        ev_t e;
        bit  ok;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got line=%0b lm=%0d tx=%0b load=%0b data=%h rdy=%0b at %0d, expected no event",
                     is_line, line_mode, tx_1_rx_0, piso_load, piso_data, tx_ready, cyc);
        end else begin
            e  = sb.pop_front();
            ok = (e.is_line == is_line) && (e.stamp == cyc);
            if (is_line) ok = ok && (e.lm == line_mode) && (e.tx == tx_1_rx_0);
            else         ok = ok && (e.data == piso_data) && (e.ready == tx_ready);
            if (ok) n_pass++;
            else $display("FAIL sb_event: got line=%0b lm=%0d tx=%0b data=%h rdy=%0b at %0d, expected line=%0b lm=%0d tx=%0b data=%h rdy=%0b at %0d",
                          is_line, line_mode, tx_1_rx_0, piso_data, tx_ready, cyc,
                          e.is_line, e.lm, e.tx, e.data, e.ready, e.stamp);
        end
    endtask

    // Monitor: any line change or PISO load is an event to be matched.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ({line_mode, tx_1_rx_0} != prev_line) begin
                    mon_check(1'b1);
                    prev_line = {line_mode, tx_1_rx_0};
                end
                if (piso_load) mon_check(1'b0);
            end
        end
    end

    // Stuff-stall driver: raises stuff_stall for the one cycle whose stamp is queued.
    initial begin
        stuff_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_q.size() > 0 && stall_q[0] == cyc) begin
                stuff_stall = 1'b1;
                void'(stall_q.pop_front());
            end else begin
                stuff_stall = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic at_stamp(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pkt(input int n, input int nhs);
        int waited;
        tx_valid = 1'b1;
        tx_data  = pkt[0];
        for (int h = 0; h < nhs; h++) begin
            waited = 0;
            while (waited < 300) begin
                @(negedge clk);
                if (tx_ready === 1'b1) break;
                waited++;
            end
            chk("handshake_seen", (waited < 300) ? 1 : 0, 1);
            @(posedge clk);
            #1;
            if (h + 1 < n) tx_data = pkt[h + 1];
            else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk(name, sb.size(), 0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_1_rx_0"}, int'(tx_1_rx_0), 0);
        chk({tag, "_line_mode"}, int'(line_mode), int'(LM_OFF));
        chk({tag, "_tx_ready"},  int'(tx_ready), 0);
        chk({tag, "_piso_load"}, int'(piso_load), 0);
        chk({tag, "_bit_tick"},  int'(bit_tick), 0);
        chk({tag, "_piso_data"}, int'(piso_data), 0);
    endtask

    initial begin
        int k;
        RST = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        prev_line = {LM_OFF, 1'b0};
        mon_en = 1'b1;
        RST = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: single byte C3, then end of packet; first bit_tick CLKS_PER_BIT after start.
        pkt[0] = 8'hC3;
        k = cyc;
        exp_pkt(k, 1, -1, 0, 1'b0);
        fork
            drive_pkt(1, 1);
            begin
                at_stamp(k + 3);
                chk("first_tick_early", int'(bit_tick), 0);
                at_stamp(k + 4);
                chk("first_tick", int'(bit_tick), 1);
            end
        join
        drain("t1_drain");

        // 2: FF then 5A, stuff stall on the 7th tick of the FF byte.
        pkt[0] = 8'hFF; pkt[1] = 8'h5A;
        k = cyc;
        exp_pkt(k, 2, 0, 0, 1'b0);
        stall_q.push_back(k + 60);
        drive_pkt(2, 2);
        drain("t2_drain");

        // 3: stuff bit after the last bit of the last byte.
        pkt[0] = 8'h3C;
        k = cyc;
        exp_pkt(k, 1, -1, 1, 1'b0);
        stall_q.push_back(k + 68);
        drive_pkt(1, 1);
        drain("t3_drain");

        // 4: tx_valid and rx_active rise together: RX wins until rx_active falls.
        pkt[0] = 8'h96;
        tx_data = pkt[0]; tx_valid = 1'b1; rx_active = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rx_wins_tx_1_rx_0", int'(tx_1_rx_0), 0);
        chk("rx_wins_piso_load", int'(piso_load), 0);
        k = cyc;
        exp_pkt(k, 1, -1, 0, 1'b0);
        rx_active = 1'b0;
        drive_pkt(1, 1);
        drain("t4_drain");

        // 5: back-to-back packets, next tx_valid raised during EOP_J.
        pkt[0] = 8'hA5;
        k = cyc;
        exp_pkt(k, 1, -1, 0, 1'b0);
        drive_pkt(1, 1);
        pkt[0] = 8'h69;
        exp_pkt(k + 89, 1, -1, 0, 1'b0);
        at_stamp(k + 78);
        chk("t5_in_eop_j", int'(line_mode), int'(LM_J));
        drive_pkt(1, 1);
        drain("t5_drain");

        // 6: RST during the 3rd data byte, then a clean packet.
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
        k = cyc;
        exp_pkt(k, 3, -1, 0, 1'b1);
        push_ev(1'b1, 8'h00, 1'b0, LM_OFF, 1'b0, k + 111);
        drive_pkt(4, 3);
        at_stamp(k + 110);
        RST = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        RST = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        drain("t6_abort_drain");
        pkt[0] = 8'hDE; pkt[1] = 8'hAD;
        k = cyc;
        exp_pkt(k, 2, -1, 0, 1'b0);
        drive_pkt(2, 2);
        drain("t6_clean_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
